// File: rtl/layer_stream_bridge.sv
// Host-side bridge between an element stream and a sequential dense layer.
// Packs a fixed-length input frame into the layer's flat bus, then starts the layer.
// When the layer reports done, it captures the flat result and streams it back out
// one element at a time with valid/ready/last.
module layer_stream_bridge #(
    parameter int unsigned IN_N  = 256,
    parameter int unsigned OUT_N = 128,
    parameter int unsigned DW    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // Input element stream
    input  logic                  s_valid,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    // Layer interface
    output logic                  layer_start,
    output logic [DW*IN_N-1:0]    layer_input_flat,
    input  logic                  layer_done,
    input  logic [DW*OUT_N-1:0]   layer_output_flat,
    // Output element stream
    output logic                  m_valid,
    output logic [DW-1:0]         m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    // Status
    output logic                  busy,
    output logic                  frame_err
);

    localparam int unsigned IN_W  = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int unsigned OUT_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;
    localparam logic [IN_W-1:0]  IN_LAST  = IN_W'(IN_N - 1);
    localparam logic [OUT_W-1:0] OUT_LAST = OUT_W'(OUT_N - 1);

    typedef enum logic [1:0] {
        StFill,
        StStart,
        StWait,
        StDrain
    } state_e;

    state_e               state_q;
    logic [IN_W-1:0]      in_idx_q;
    logic [OUT_W-1:0]     out_idx_q;
    logic [DW*OUT_N-1:0]  out_buf_q;
    logic [OUT_W-1:0]     out_nxt;
    logic                 in_hs;
    logic                 in_at_last;

    // Handshake and index helpers derived from the current state
    assign s_ready    = (state_q == StFill);
    assign busy       = (state_q != StFill);
    assign in_hs      = s_valid && s_ready;
    assign in_at_last = (in_idx_q == IN_LAST);
    assign out_nxt    = out_idx_q + 1'b1;

    // Frame sequencing FSM with registered layer and output-stream signals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StFill;
            in_idx_q         <= '0;
            out_idx_q        <= '0;
            out_buf_q        <= '0;
            layer_input_flat <= '0;
            layer_start      <= 1'b0;
            m_valid          <= 1'b0;
            m_data           <= '0;
            m_last           <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            layer_start <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state_q)
                StFill: begin
                    if (in_hs) begin
                        layer_input_flat[int'(in_idx_q)*DW +: DW] <= s_data;
                        // Length is fixed; s_last only flags a mismatch, never ends the frame
                        frame_err <= (s_last != in_at_last);
                        if (in_at_last) begin
                            in_idx_q    <= '0;
                            layer_start <= 1'b1;
                            state_q     <= StStart;
                        end else begin
                            in_idx_q <= in_idx_q + 1'b1;
                        end
                    end
                end
                StStart: begin
                    state_q <= StWait;
                end
                StWait: begin
                    if (layer_done) begin
                        // Result bus is only valid in the done cycle, so grab it now
                        out_buf_q <= layer_output_flat;
                        out_idx_q <= '0;
                        m_valid   <= 1'b1;
                        m_data    <= layer_output_flat[DW-1:0];
                        m_last    <= (OUT_N == 1);
                        state_q   <= StDrain;
                    end
                end
                StDrain: begin
                    if (m_valid && m_ready) begin
                        if (out_idx_q == OUT_LAST) begin
                            out_idx_q <= '0;
                            m_valid   <= 1'b0;
                            m_last    <= 1'b0;
                            state_q   <= StFill;
                        end else begin
                            out_idx_q <= out_nxt;
                            m_data    <= out_buf_q[int'(out_nxt)*DW +: DW];
                            m_last    <= (out_nxt == OUT_LAST);
                        end
                    end
                end
                default: begin
                    state_q <= StFill;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_stream_bridge.sv
// Self-checking bench for layer_stream_bridge with a behavioural layer stub.
module tb_layer_stream_bridge;

    localparam int IN_N  = 256;
    localparam int OUT_N = 128;
    localparam int DW    = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 s_valid;
    logic [DW-1:0]        s_data;
    logic                 s_last;
    logic                 s_ready;
    logic                 layer_start;
    logic [DW*IN_N-1:0]   layer_input_flat;
    logic                 layer_done;
    logic [DW*OUT_N-1:0]  layer_output_flat;
    logic                 m_valid;
    logic [DW-1:0]        m_data;
    logic                 m_last;
    logic                 m_ready;
    logic                 busy;
    logic                 frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_count;
    int fe_at;
    int ls_count;

    logic [DW-1:0] in_vec  [IN_N];
    logic [DW-1:0] exp_out [OUT_N];

    always #5 clk = ~clk;

    layer_stream_bridge #(
        .IN_N (IN_N),
        .OUT_N(OUT_N),
        .DW   (DW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .s_valid          (s_valid),
        .s_data           (s_data),
        .s_last           (s_last),
        .s_ready          (s_ready),
        .layer_start      (layer_start),
        .layer_input_flat (layer_input_flat),
        .layer_done       (layer_done),
        .layer_output_flat(layer_output_flat),
        .m_valid          (m_valid),
        .m_data           (m_data),
        .m_last           (m_last),
        .m_ready          (m_ready),
        .busy             (busy),
        .frame_err        (frame_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (frame_err === 1'b1) fe_count++;
        if (layer_start === 1'b1) ls_count++;
    endtask

    task automatic garbage_output();
        for (int j = 0; j < OUT_N; j++) layer_output_flat[j*DW +: DW] = 16'($urandom);
    endtask

    // Stream in_vec into the bridge; s_last at the true end and optionally at err_at
    task automatic feed_frame(input int err_at, input bit inject_done);
        int guard;
        fe_count = 0;
        ls_count = 0;
        fe_at    = -1;
        for (int k = 0; k < IN_N; k++) begin
            s_valid = 1'b1;
            s_data  = in_vec[k];
            s_last  = (k == IN_N - 1) || (k == err_at);
            guard   = 0;
            while (s_ready !== 1'b1 && guard <= 100) begin
                tick();
                guard++;
            end
            if (guard > 100) begin
                chk("fill_ready_timeout", 32'd0, 32'd1);
                break;
            end
            if (inject_done && k == 50) begin
                garbage_output();
                layer_done = 1'b1;
            end
            tick();
            layer_done = 1'b0;
            if (frame_err === 1'b1 && fe_at < 0) fe_at = k;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("start_latency", layer_start, 1);
        chk("start_busy", busy, 1);
        chk("start_s_ready", s_ready, 0);
    endtask

    task automatic check_packing();
        int bad;
        bad = 0;
        for (int k = 0; k < IN_N; k++)
            if (layer_input_flat[k*DW +: DW] !== in_vec[k]) bad++;
        chk("pack_all_bad", bad, 0);
    endtask

    // Behavioural layer: mode 0 -> 0x8000+j, mode 1 -> in[2j]+in[2j+1]
    task automatic run_layer(input int mode, input int delay);
        int busy_bad, mv_bad, rdy_bad;
        logic [DW-1:0] a, b;
        busy_bad = 0;
        mv_bad   = 0;
        rdy_bad  = 0;
        for (int c = 0; c < delay; c++) begin
            tick();
            if (busy !== 1'b1) busy_bad++;
            if (m_valid !== 1'b0) mv_bad++;
            if (s_ready !== 1'b0) rdy_bad++;
        end
        chk("wait_busy_bad", busy_bad, 0);
        chk("wait_mvalid_bad", mv_bad, 0);
        chk("wait_sready_bad", rdy_bad, 0);
        chk("start_pulse_count", ls_count, 1);
        for (int j = 0; j < OUT_N; j++) begin
            a = layer_input_flat[(2*j)*DW +: DW];
            b = layer_input_flat[(2*j+1)*DW +: DW];
            layer_output_flat[j*DW +: DW] = (mode == 0) ? 16'(16'h8000 + j) : 16'(a + b);
        end
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        garbage_output();
        chk("done_to_mvalid", m_valid, 1);
    endtask

    // Drain with pattern 0: always ready, 1: 1,0,0,1 repeating, 2: random
    task automatic drain(input int pattern, input bit inject_done);
        int got, cyc, data_bad, last_bad, stall_bad, rdy_bad, busy_bad;
        logic [DW-1:0] prev_data;
        logic prev_last;
        bit prev_stall;
        got = 0; cyc = 0; data_bad = 0; last_bad = 0; stall_bad = 0;
        rdy_bad = 0; busy_bad = 0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        while (got < OUT_N && cyc < 4000) begin
            if (prev_stall && (m_data !== prev_data || m_last !== prev_last)) stall_bad++;
            if (s_ready !== 1'b0) rdy_bad++;
            if (busy !== 1'b1) busy_bad++;
            case (pattern)
                0:       m_ready = 1'b1;
                1:       m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject_done && cyc == 5) layer_done = 1'b1;
            if (m_valid === 1'b1 && m_ready) begin
                if (m_data !== exp_out[got]) data_bad++;
                if (m_last !== (got == OUT_N - 1)) last_bad++;
                got++;
            end
            prev_stall = (m_valid === 1'b1) && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            tick();
            layer_done = 1'b0;
            cyc++;
        end
        m_ready = 1'b0;
        chk("drain_count", got, OUT_N);
        chk("drain_data_bad", data_bad, 0);
        chk("drain_last_bad", last_bad, 0);
        chk("drain_stall_bad", stall_bad, 0);
        chk("drain_sready_bad", rdy_bad, 0);
        chk("drain_busy_bad", busy_bad, 0);
        chk("post_drain_mvalid", m_valid, 0);
        chk("post_drain_sready", s_ready, 1);
        chk("post_drain_busy", busy, 0);
    endtask

    task automatic model_sum();
        for (int j = 0; j < OUT_N; j++) exp_out[j] = 16'(in_vec[2*j] + in_vec[2*j+1]);
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        layer_done = 1'b0; layer_output_flat = '0; m_ready = 1'b0;
        fe_count = 0; ls_count = 0; fe_at = -1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Reset and idle state
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_layer_start", layer_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flat_nonzero", |layer_input_flat, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_frame_err", frame_err, 0);

        // Reset in the middle of a fill discards the partial frame
        for (int k = 0; k < IN_N; k++) in_vec[k] = 16'($urandom_range(1, 16'hFFFF));
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1;
            s_data  = in_vec[k];
            s_last  = 1'b0;
            tick();
        end
        s_valid = 1'b0;
        chk("partial_elem3", layer_input_flat[3*DW +: DW], in_vec[3]);
        rst = 1'b1;
        #1;
        chk("midrst_flat_nonzero", |layer_input_flat, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        tick();
        rst = 1'b0;
        tick();

        // Packing frame k=0..255 with a stray layer_done during fill and drain
        for (int k = 0; k < IN_N; k++) in_vec[k] = 16'(k);
        feed_frame(-1, 1'b1);
        chk("pack_frame_err_count", fe_count, 0);
        check_packing();
        chk("pack_elem17", layer_input_flat[17*DW +: DW], 16'h0011);
        chk("pack_elem255", layer_input_flat[255*DW +: DW], 16'h00FF);
        for (int j = 0; j < OUT_N; j++) exp_out[j] = 16'(16'h8000 + j);
        run_layer(0, 40);
        drain(0, 1'b1);

        // Early s_last at element 100: one error pulse, frame still full length
        for (int k = 0; k < IN_N; k++) in_vec[k] = 16'($urandom);
        feed_frame(100, 1'b0);
        chk("len_frame_err_count", fe_count, 1);
        chk("len_frame_err_at", fe_at, 100);
        check_packing();
        model_sum();
        run_layer(1, 40);
        drain(1, 1'b0);

        // Back-to-back random frames with random latency and backpressure
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < IN_N; k++) in_vec[k] = 16'($urandom);
            feed_frame(-1, 1'b0);
            chk("b2b_frame_err_count", fe_count, 0);
            check_packing();
            model_sum();
            run_layer(1, $urandom_range(1, 60));
            drain(2, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_stream_bridge.md
Name: layer_stream_bridge

Overview:
- Host-side controller for the sequential dense-layer generators (start/done handshake, flattened signed 16-bit input and output buses).
- Accepts an input vector as a valid/ready element stream and packs it into the layer's flat input bus.
- Pulses the layer start, waits for done, captures the flat output bus, then streams the result out element by element with valid/ready/last.
- Sits between the streaming datapath (DMA/testbench feeder) and a layer instance, e.g. the 256-in/128-out layer 3 generator.

Parameters:
IN_N, 256, number of input elements per frame (layer input vector length)
OUT_N, 128, number of output elements per frame (layer output vector length)
DW, 16, element width in bits (signed Q8.8)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
s_valid  input  1  input element valid
s_data  input  DW  input element, signed
s_last  input  1  sender marks final element of frame
s_ready  output  1  bridge accepts input element
layer_start  output  1  one-cycle start pulse to layer
layer_input_flat  output  DW*IN_N  packed input vector; element k at bits [(k+1)*DW-1 -: DW]
layer_done  input  1  layer completion pulse; layer_output_flat valid in the same cycle
layer_output_flat  input  DW*OUT_N  packed layer result, same packing
m_valid  output  1  output element valid
m_data  output  DW  output element, signed
m_last  output  1  high with element OUT_N-1
m_ready  input  1  downstream accepts output element
busy  output  1  high in every state except FILL
frame_err  output  1  one-cycle pulse on s_last/length mismatch

Behaviour:
- Reset (rst high, asynchronous): state=FILL, in_idx=0, out_idx=0, layer_input_flat=0, output buffer=0, layer_start=0, m_valid=0, m_data=0, m_last=0, frame_err=0, busy=0. s_ready=1 on the first cycle after reset release. Reset mid-operation aborts the frame; a partially filled vector is discarded and layer_input_flat returns to 0.
- State FILL: s_ready=1.
  - On s_valid&&s_ready: write s_data to element in_idx of layer_input_flat; in_idx++.
  - frame_err pulses for exactly one cycle when s_last != (in_idx==IN_N-1) at a handshake. Frame length is fixed; s_last never truncates or extends it.
  - Handshake with in_idx==IN_N-1 -> START, in_idx=0.
- State START: s_ready=0. layer_start=1 for exactly this one cycle -> WAIT. layer_input_flat is held constant from START until the next FILL handshake.
- State WAIT: s_ready=0, layer_start=0.
  - On layer_done=1: copy layer_output_flat into the internal output buffer in that same cycle, out_idx=0 -> DRAIN.
  - No timeout; the bridge waits indefinitely.
  - layer_done in any other state is ignored.
- State DRAIN: m_valid=1, m_data=buffer[out_idx], m_last=(out_idx==OUT_N-1), registered.
  - m_data and m_last stay stable while m_valid&&!m_ready.
  - On m_valid&&m_ready: out_idx++. The handshake on element OUT_N-1 -> FILL, with m_valid=0 on the next cycle.
  - s_ready=0 throughout DRAIN; there is no overlap of the next fill with the drain.
- busy = (state != FILL).
- Data is passed through bit-exact; the bridge does no arithmetic, saturation or reordering.
- Latency:
  - From the last input handshake to layer_start: 1 cycle.
  - From layer_done to first m_valid: 1 cycle.
  - Output rate: 1 element/cycle when m_ready is held high.
- Element indexing: in_idx is clog2(IN_N) bits and out_idx is clog2(OUT_N) bits; both wrap to 0 only through the state transitions above.

Test Plan:
- Reset then idle: s_ready=1, m_valid=0, layer_start=0, busy=0, layer_input_flat=0. Assert rst mid-FILL after 10 elements -> all outputs return to reset values and the next frame starts at element 0.
- Input packing: stream s_data=k for k=0..255 with s_last on k=255 and s_valid always high -> layer_start high for exactly 1 cycle, 1 cycle after handshake 255. Element 17 of layer_input_flat = 0x0011, element 255 = 0x00FF. frame_err never pulses.
- Length error: s_last on element 100 and also on element 255 -> frame_err pulses once (at element 100). Frame still completes at 256 elements; layer_start fires once.
- Layer stub with done 40 cycles after start and output element j = 0x8000+j -> m_valid rises 1 cycle after done. m_data sequence is 0x8000..0x807F; m_last only on 0x807F. A layer_done injected during FILL or DRAIN has no effect.
- Backpressure: m_ready toggled 1,0,0,1 repeating -> no element dropped or duplicated; m_data stable while stalled. s_ready=0 until the last output handshake, then 1 on the next cycle.
- Back-to-back frames with the real 256x128 layer: two frames of different inputs -> each output frame matches the reference model, and busy is high from the first START to the final DRAIN handshake of each frame.
